// File: rtl/bpred_pkg.sv
// bpred_pkg
//   Shared types and helpers for the fetch-stage branch predictor.
//   XLEN, TAG_W and CTR_W fix the field widths of a BTB entry.
//   btb_entry_t is one BTB line: valid, jump flag, tag, target and direction counter.
//   ctr_next() is the saturating counter step, with the same behaviour as sat_counter.
package bpred_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 8;
  localparam int CTR_W = 2;

  typedef struct packed {
    logic             valid;
    logic             is_jump;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } btb_entry_t;

  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] ctr, input logic taken);
    logic [CTR_W-1:0] result;
    result = ctr;
    if (taken && (ctr != {CTR_W{1'b1}})) result = ctr + 1'b1;
    else if (!taken && (ctr != '0))     result = ctr - 1'b1;
    return result;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Combinational saturating up/down counter step.
//   Ports:
//     ctr     in   CTR_W  current counter value
//     taken   in   1      count up when 1, down when 0
//     ctrNext out  CTR_W  next value, held at 0 and at 2^CTR_W-1
module sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] ctrNext
);

  localparam logic [CTR_W-1:0] CtrMax = {CTR_W{1'b1}};

  always_comb begin
    ctrNext = ctr;
    if (taken) begin
      if (ctr != CtrMax) ctrNext = ctr + 1'b1;
    end else begin
      if (ctr != '0) ctrNext = ctr - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped branch target buffer with per-entry saturating direction counters.
//   It predicts the next fetch PC from pcF in the same cycle. It trains from the
//   branch or jump resolved in E, and flags mispredicts so the pipe can be redirected.
//   Ports:
//     clk, reset_n                 clock, asynchronous active-low reset
//     pcF                          current fetch PC
//     pred_takenF, pred_pcF        prediction for the instruction at pcF
//     upd_valid .. upd_pred_target resolved branch/jump and the prediction it carried
//     invalidate                   clears every valid bit (fence.i / context switch)
//     mispredict, redirect_pc      resolution check and the corrected next PC
//     perf_branches                count of resolved branches, wraps modulo 2^PERF_W
//     perf_mispredicts             count of mispredicts, wraps modulo 2^PERF_W
module branch_predictor
  import bpred_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [XLEN-1:0]   pcF,
  output logic              pred_takenF,
  output logic [XLEN-1:0]   pred_pcF,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_target,
  input  logic              invalidate,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CtrWeakTaken = {1'b1, {(CTR_W-1){1'b0}}};

  btb_entry_t btb [ENTRIES];

  logic [IDX_W-1:0] fetchIdx;
  logic [TAG_W-1:0] fetchTag;
  btb_entry_t       fetchEntry;
  logic             fetchHit;

  logic [IDX_W-1:0] updIdx;
  logic [TAG_W-1:0] updTag;
  btb_entry_t       updEntry;
  logic             updHit;
  logic             updLegal;
  logic [CTR_W-1:0] updCtrNext;

  // Fetch lookup reads the stored state only. A same-cycle update to the same
  // line is not bypassed, so fetch sees the line as it was before that update.
  always_comb begin
    fetchIdx    = pcF[IDX_W+1:2];
    fetchTag    = pcF[IDX_W+2 +: TAG_W];
    fetchEntry  = btb[fetchIdx];
    fetchHit    = fetchEntry.valid && (fetchEntry.tag == fetchTag);
    pred_takenF = fetchHit && (fetchEntry.is_jump || fetchEntry.ctr[CTR_W-1]);
    pred_pcF    = pred_takenF ? fetchEntry.target : pcF + XLEN'(4);
  end

  // Resolution check against the prediction that travelled down the pipe.
  always_comb begin
    mispredict  = upd_valid &&
                  ((upd_taken != upd_pred_taken) ||
                   (upd_taken && (upd_target != upd_pred_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
  end

  // A jump reported as not taken is malformed. It trains nothing.
  always_comb begin
    updIdx   = upd_pc[IDX_W+1:2];
    updTag   = upd_pc[IDX_W+2 +: TAG_W];
    updEntry = btb[updIdx];
    updHit   = updEntry.valid && (updEntry.tag == updTag);
    updLegal = !(upd_is_jump && !upd_taken);
  end

  sat_counter #(.CTR_W(CTR_W)) updCounter (
    .ctr     (updEntry.ctr),
    .taken   (upd_taken),
    .ctrNext (updCtrNext)
  );

  // BTB storage. invalidate drops only the valid bits and wins over a
  // same-cycle update. A miss allocates only when the branch was taken,
  // and a new line starts in the weakly-taken state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) btb[i] <= '0;
    end else if (invalidate) begin
      for (int i = 0; i < ENTRIES; i++) btb[i].valid <= 1'b0;
    end else if (upd_valid && updLegal) begin
      if (updHit) begin
        btb[updIdx].ctr <= updCtrNext;
        if (upd_taken) begin
          btb[updIdx].target  <= upd_target;
          btb[updIdx].is_jump <= upd_is_jump;
        end
      end else if (upd_taken) begin
        btb[updIdx].valid   <= 1'b1;
        btb[updIdx].tag     <= updTag;
        btb[updIdx].target  <= upd_target;
        btb[updIdx].is_jump <= upd_is_jump;
        btb[updIdx].ctr     <= CtrWeakTaken;
      end
    end
  end

  // Performance counters keep counting during an invalidate cycle and wrap freely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      perf_branches    <= perf_branches + PERF_W'(upd_valid);
      perf_mispredicts <= perf_mispredicts + PERF_W'(mispredict);
    end
  end

  illegalJumpUpdate: assert property (@(posedge clk) disable iff (!reset_n)
    upd_valid |-> !(upd_is_jump && !upd_taken));

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
//   Randomized and directed stimulus for branch_predictor. The bench keeps its
//   own model of the BTB as plain per-line arrays with integer counters, and it
//   checks every combinational output and both performance counters each cycle.
module tb_branch_predictor;
  import bpred_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pcF;
  logic        pred_takenF;
  logic [31:0] pred_pcF;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        invalidate;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  int testsRun    = 0;
  int testsFailed = 0;

  bit          mValid  [16];
  bit          mJump   [16];
  int unsigned mTag    [16];
  logic [31:0] mTarget [16];
  int          mCtr    [16];
  logic [31:0] mBranches;
  logic [31:0] mMisp;

  branch_predictor #(.ENTRIES(16), .PERF_W(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pcF              (pcF),
    .pred_takenF      (pred_takenF),
    .pred_pcF         (pred_pcF),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_is_jump      (upd_is_jump),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .invalidate       (invalidate),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 0; mJump[i] = 0; mTag[i] = 0; mTarget[i] = '0; mCtr[i] = 0;
    end
    mBranches = '0;
    mMisp     = '0;
  endtask

  task automatic modelLookup(input logic [31:0] pc, output bit taken, output logic [31:0] npc);
    int i;
    bit hit;
    i     = int'((pc / 4) % 16);
    hit   = mValid[i] && (mTag[i] == (pc / 64) % 256);
    taken = hit && (mJump[i] || mCtr[i] >= 2);
    npc   = taken ? mTarget[i] : pc + 4;
  endtask

  function automatic bit modelMisp();
    if (!upd_valid) return 0;
    if (upd_taken != upd_pred_taken) return 1;
    return upd_taken && (upd_target != upd_pred_target);
  endfunction

  // Applies one clock edge's worth of training to the model.
  task automatic modelUpdate(input bit misp);
    int i;
    bit hit;
    if (upd_valid) mBranches = mBranches + 1;
    if (misp)      mMisp     = mMisp + 1;
    i   = int'((upd_pc / 4) % 16);
    hit = mValid[i] && (mTag[i] == (upd_pc / 64) % 256);
    if (invalidate) begin
      for (int k = 0; k < 16; k++) mValid[k] = 0;
    end else if (upd_valid && !(upd_is_jump && !upd_taken)) begin
      if (hit) begin
        mCtr[i] = upd_taken ? ((mCtr[i] + 1 > 3) ? 3 : mCtr[i] + 1)
                            : ((mCtr[i] - 1 < 0) ? 0 : mCtr[i] - 1);
        if (upd_taken) begin
          mTarget[i] = upd_target;
          mJump[i]   = upd_is_jump;
        end
      end else if (upd_taken) begin
        mValid[i]  = 1;
        mTag[i]    = (upd_pc / 64) % 256;
        mTarget[i] = upd_target;
        mJump[i]   = upd_is_jump;
        mCtr[i]    = 2;
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                               input bit jump, input bit taken, input logic [31:0] tgt,
                               input bit pt, input logic [31:0] ptgt, input bit inv);
    pcF = pc; upd_valid = uv; upd_pc = upc; upd_is_jump = jump; upd_taken = taken;
    upd_target = tgt; upd_pred_taken = pt; upd_pred_target = ptgt; invalidate = inv;
  endtask

  task automatic idleAt(input logic [31:0] pc);
    applyStimulus(pc, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  // Called just after a falling edge: let inputs settle, then compare against the model.
  task automatic settle();
    bit          expTaken;
    logic [31:0] expNpc;
    #1;
    modelLookup(pcF, expTaken, expNpc);
    checkOutput("pred_takenF", {31'b0, pred_takenF}, {31'b0, expTaken});
    checkOutput("pred_pcF", pred_pcF, expNpc);
    checkOutput("mispredict", {31'b0, mispredict}, {31'b0, modelMisp()});
    checkOutput("redirect_pc", redirect_pc, upd_taken ? upd_target : upd_pc + 4);
    checkOutput("perf_branches", perf_branches, mBranches);
    checkOutput("perf_mispredicts", perf_mispredicts, mMisp);
  endtask

  task automatic advance();
    bit misp;
    misp = modelMisp();
    @(posedge clk);
    modelUpdate(misp);
    @(negedge clk);
  endtask

  task automatic predictedFor(input logic [31:0] pc, output bit pt, output logic [31:0] ptgt);
    modelLookup(pc, pt, ptgt);
  endtask

  initial begin
    bit          pt;
    logic [31:0] ptgt;

    reset_n = 1'b0;
    idleAt(32'h100);
    modelReset();
    #12;
    checkOutput("reset_pred_takenF", {31'b0, pred_takenF}, 32'h0);
    checkOutput("reset_pred_pcF", pred_pcF, 32'h104);
    checkOutput("reset_mispredict", {31'b0, mispredict}, 32'h0);
    checkOutput("reset_perf_branches", perf_branches, 32'h0);
    checkOutput("reset_perf_mispredicts", perf_mispredicts, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // First taken branch at 0x100 allocates as weakly taken.
    applyStimulus(32'h100, 1, 32'h100, 0, 1, 32'h140, 0, 32'h104, 0);
    settle();
    checkOutput("t2_mispredict", {31'b0, mispredict}, 32'h1);
    checkOutput("t2_redirect", redirect_pc, 32'h140);
    advance();
    idleAt(32'h100);
    settle();
    checkOutput("t2_pred_taken", {31'b0, pred_takenF}, 32'h1);
    checkOutput("t2_pred_pc", pred_pcF, 32'h140);
    advance();

    // Saturate at 3, then walk down to 1.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(32'h100, 1, 32'h100, 0, 1, 32'h140, 1, 32'h140, 0);
      settle();
      advance();
    end
    for (int k = 0; k < 2; k++) begin
      predictedFor(32'h100, pt, ptgt);
      applyStimulus(32'h100, 1, 32'h100, 0, 0, 32'h140, pt, ptgt, 0);
      settle();
      if (k == 0) begin
        checkOutput("t3_nt_mispredict", {31'b0, mispredict}, 32'h1);
        checkOutput("t3_nt_redirect", redirect_pc, 32'h104);
      end
      advance();
    end
    idleAt(32'h100);
    settle();
    checkOutput("t3_ctr1_pred_pc", pred_pcF, 32'h104);
    advance();

    // An alias at index 0 with a different tag misses, then a jal evicts 0x100.
    idleAt(32'h140);
    settle();
    checkOutput("t4_alias_pred_pc", pred_pcF, 32'h144);
    advance();
    applyStimulus(32'h140, 1, 32'h140, 1, 1, 32'h200, 0, 32'h144, 0);
    settle();
    advance();
    idleAt(32'h100);
    settle();
    checkOutput("t4_evicted_pred_pc", pred_pcF, 32'h104);
    advance();
    idleAt(32'h140);
    settle();
    checkOutput("t4_jump_pred_pc", pred_pcF, 32'h200);
    advance();

    // invalidate wins over a same-cycle taken update.
    applyStimulus(32'h140, 1, 32'h180, 0, 1, 32'h1c0, 0, 32'h184, 1);
    settle();
    advance();
    idleAt(32'h180);
    settle();
    checkOutput("t5_inv_pred_pc", pred_pcF, 32'h184);
    checkOutput("t5_perf_branches", perf_branches, 32'd7);
    advance();
    idleAt(32'h140);
    settle();
    checkOutput("t5_inv_jump_pred_pc", pred_pcF, 32'h144);
    advance();

    // Target comparison matters only when the branch is taken.
    applyStimulus(32'h0, 1, 32'h100, 0, 1, 32'h140, 1, 32'h140, 0);
    settle();
    checkOutput("t6_match_mispredict", {31'b0, mispredict}, 32'h0);
    advance();
    applyStimulus(32'h0, 1, 32'h100, 0, 1, 32'h140, 1, 32'h150, 0);
    settle();
    checkOutput("t6_target_mispredict", {31'b0, mispredict}, 32'h1);
    advance();
    idleAt(32'h0);
    settle();
    checkOutput("t6_perf_mispredicts", perf_mispredicts, 32'd6);
    checkOutput("t6_perf_branches", perf_branches, 32'd9);
    advance();

    // Random traffic over a small address pool, so lines hit, alias and evict.
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic [31:0] fpc, upc, tgt;
      bit uv, jump, taken, inv;
      if (cyc == 400) begin
        // Asynchronous reset between edges clears everything at once.
        #1;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midreset_pred_pcF", pred_pcF, pcF + 4);
        checkOutput("midreset_perf_branches", perf_branches, 32'h0);
        checkOutput("midreset_perf_mispredicts", perf_mispredicts, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
      end
      fpc   = 32'h1000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      upc   = 32'h1000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      tgt   = $urandom & 32'hffff_fffc;
      uv    = ($urandom_range(0, 3) != 0);
      jump  = ($urandom_range(0, 4) == 0);
      taken = jump ? 1'b1 : $urandom_range(0, 1) == 1;
      inv   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) == 0) begin
        modelLookup(upc, pt, ptgt);
        if (pt) tgt = ptgt;
      end
      predictedFor(upc, pt, ptgt);
      if ($urandom_range(0, 7) == 0) pt = !pt;
      if ($urandom_range(0, 7) == 0) ptgt = ptgt ^ 32'h10;
      applyStimulus(fpc, uv, upc, jump, taken, tgt, pt, ptgt, inv);
      settle();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no finish, expected finish within time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
